// File: rtl/adder_subtractor_24bit_pkg.sv
// adder_subtractor_24bit_pkg: shared width and opcode constants for the mantissa adder/subtractor
package adder_subtractor_24bit_pkg;
  localparam int WIDTH = 24;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/adder_subtractor_24bit_full_adder.sv
// full_adder: one-bit full adder cell of the ripple-carry chain
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/adder_subtractor_24bit.sv
// adder_subtractor_24bit: registered 24-bit ripple-carry add/subtract with steered results and carry-out
module adder_subtractor_24bit
  import adder_subtractor_24bit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ctl,
  input  logic             enable,
  output logic [WIDTH-1:0] Sum,
  output logic [WIDTH-1:0] Difference,
  output logic             Cout
);
  logic [WIDTH:0] c;
  logic [WIDTH-1:0] r, sum_d, sum_q, diff_d, diff_q;
  logic cout_d, cout_q;
  assign c[0] = Ctl;
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_rc
      full_adder u_fa (.a(A[i]), .b(B[i] ^ Ctl), .cin(c[i]), .s(r[i]), .cout(c[i+1]));
    end
  endgenerate
  // steer the chain result into the active register, clear the other, hold everything when idle
  always_comb begin
    sum_d = enable ? (Ctl == OP_ADD ? r : '0) : sum_q;
    diff_d = enable ? (Ctl == OP_SUB ? r : '0) : diff_q;
    cout_d = enable ? c[WIDTH] : cout_q;
  end
  // output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sum_q <= '0;
      diff_q <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      diff_q <= diff_d;
      cout_q <= cout_d;
    end
  assign Sum = sum_q;
  assign Difference = diff_q;
  assign Cout = cout_q;
endmodule

// File: tb/tb_adder_subtractor_24bit.sv
// tb_adder_subtractor_24bit: self-checking bench with directed cases and a randomized arithmetic reference model
module tb_adder_subtractor_24bit;
  logic clk = 1'b0;
  logic rst_n;
  logic [23:0] A, B, Sum, Difference;
  logic Ctl, enable, Cout;
  int checks = 0;
  int errors = 0;

  adder_subtractor_24bit dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Ctl(Ctl), .enable(enable),
    .Sum(Sum), .Difference(Difference), .Cout(Cout)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [23:0] a, input logic [23:0] b, input logic ctl,
                                output logic [23:0] s, output logic [23:0] d, output logic co);
    int unsigned ua, ub;
    ua = a;
    ub = b;
    if (!ctl) begin
      s = 24'((ua + ub) % 32'h100_0000);
      d = 24'd0;
      co = (ua + ub) >= 32'h100_0000;
    end else begin
      s = 24'd0;
      d = 24'((ua + 32'h100_0000 - ub) % 32'h100_0000);
      co = ua >= ub;
    end
  endfunction

  task automatic drive(input logic [23:0] a, input logic [23:0] b, input logic ctl, input logic en);
    @(negedge clk);
    A = a;
    B = b;
    Ctl = ctl;
    enable = en;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    A = 24'h123456;
    B = 24'hABCDEF;
    Ctl = 1'b0;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (Sum !== 24'd0 || Difference !== 24'd0 || Cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got sum=%h diff=%h cout=%b exp 0/0/0", Sum, Difference, Cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b0;
    repeat (2) drive(24'h00FFFF, 24'h000001, 1'b0, 1'b0);
    checks++;
    if (Sum !== 24'd0 || Difference !== 24'd0 || Cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle got sum=%h diff=%h cout=%b exp 0/0/0", Sum, Difference, Cout);
    end
  endtask

  task automatic test_add();
    logic [23:0] ta[3] = '{24'd28, 24'd255, 24'hFFFFFF};
    logic [23:0] tb[3] = '{24'd34, 24'd34, 24'd1};
    logic [23:0] ts[3] = '{24'd62, 24'd289, 24'd0};
    logic tc[3] = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      drive(ta[k], tb[k], 1'b0, 1'b1);
      checks++;
      if (Sum !== ts[k] || Cout !== tc[k] || Difference !== 24'd0) begin
        errors++;
        $display("FAIL add_%0d got sum=%h diff=%h cout=%b exp sum=%h diff=0 cout=%b", k, Sum, Difference, Cout, ts[k], tc[k]);
      end
    end
  endtask

  task automatic test_sub();
    logic [23:0] ta[4] = '{24'd28, 24'd255, 24'd0, 24'd2222};
    logic [23:0] tb[4] = '{24'd34, 24'd34, 24'd1, 24'd2222};
    logic [23:0] td[4] = '{24'hFFFFFA, 24'd221, 24'hFFFFFF, 24'd0};
    logic tc[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      drive(ta[k], tb[k], 1'b1, 1'b1);
      checks++;
      if (Difference !== td[k] || Cout !== tc[k] || Sum !== 24'd0) begin
        errors++;
        $display("FAIL sub_%0d got sum=%h diff=%h cout=%b exp sum=0 diff=%h cout=%b", k, Sum, Difference, Cout, td[k], tc[k]);
      end
    end
  endtask

  task automatic test_hold();
    drive(24'd0, 24'd1, 1'b1, 1'b1);
    drive(24'd1, 24'd0, 1'b1, 1'b0);
    drive(24'd2222, 24'd2222, 1'b1, 1'b0);
    drive(24'd5, 24'd7, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (Difference !== 24'hFFFFFF || Cout !== 1'b0 || Sum !== 24'd0) begin
        errors++;
        $display("FAIL hold_%0d got sum=%h diff=%h cout=%b exp sum=0 diff=ffffff cout=0", k, Sum, Difference, Cout);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] a, b, es, ed;
    logic ctl, ec;
    for (int k = 0; k < 200; k++) begin
      a = 24'($urandom);
      b = (k % 10 == 0) ? a : 24'($urandom);
      if (k % 7 == 0) a = 24'hFFFFFF;
      ctl = (k % 3 == 2) ? 1'($urandom) : 1'(k % 2);
      model(a, b, ctl, es, ed, ec);
      drive(a, b, ctl, 1'b1);
      checks++;
      if (Sum !== es || Difference !== ed || Cout !== ec) begin
        errors++;
        $display("FAIL rand_%0d a=%h b=%h ctl=%b got sum=%h diff=%h cout=%b exp sum=%h diff=%h cout=%b",
                 k, a, b, ctl, Sum, Difference, Cout, es, ed, ec);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(24'hFFFFFF, 24'd1, 1'b0, 1'b1);
    drive(24'd255, 24'd34, 1'b1, 1'b1);
    checks++;
    if (Difference !== 24'd221 || Cout !== 1'b1) begin
      errors++;
      $display("FAIL async_pre got diff=%h cout=%b exp diff=0000dd cout=1", Difference, Cout);
    end
    @(negedge clk);
    A = 24'd28;
    B = 24'd34;
    Ctl = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (Sum !== 24'd0 || Difference !== 24'd0 || Cout !== 1'b0) begin
      errors++;
      $display("FAIL async_clear got sum=%h diff=%h cout=%b exp 0/0/0", Sum, Difference, Cout);
    end
    @(posedge clk);
    #1;
    checks++;
    if (Sum !== 24'd0 || Difference !== 24'd0 || Cout !== 1'b0) begin
      errors++;
      $display("FAIL async_held got sum=%h diff=%h cout=%b exp 0/0/0", Sum, Difference, Cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(24'd28, 24'd34, 1'b0, 1'b1);
    checks++;
    if (Sum !== 24'd62 || Difference !== 24'd0 || Cout !== 1'b0) begin
      errors++;
      $display("FAIL async_recover got sum=%h diff=%h cout=%b exp sum=00003e diff=0 cout=0", Sum, Difference, Cout);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_hold();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
